mips_ex_agu_ctrl: RTL and testbench
===================================

# mips_ex_agu_ctrl

Sequencer for load/store instructions in the EX stage. It sits on the requestor side of the shared ALU datapath's AGU port: it issues the address add, captures the effective address, and drives a valid/ready data-memory command. For loads it also collects the response, aligns it, extends it and returns it for writeback. It handles one memory instruction at a time and flags misaligned accesses instead of issuing them.

## Interface
Parameters:
- MIPS_DATA_WIDTH, 32, data width (fixed at 32; byte-lane logic assumes 4 lanes)
- MIPS_ADDR_WIDTH, 32, memory address width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- agu_i_valid  in  1  instruction offered
- agu_i_ready  out  1  block can accept
- agu_i_load  in  1  1 = load, 0 = store
- agu_i_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- agu_i_usign  in  1  zero-extend load result (LBU/LHU)
- agu_i_rs  in  32  base register value
- agu_i_imm  in  32  sign-extended offset
- agu_i_wdata  in  32  store data (rt)
- agu_i_rd  in  5  load destination register
- agu_req_alu  out  1  AGU request to the shared ALU
- agu_req_alu_op1 / agu_req_alu_op2  out  32  base / offset
- agu_req_alu_add  out  1  add opcode
- agu_req_alu_res  in  32  combinational sum from the ALU
- mem_cmd_valid  out  1  memory command valid
- mem_cmd_ready  in  1  memory accepts the command
- mem_cmd_read  out  1  1 = read
- mem_cmd_addr  out  32  word-aligned address ({ea[31:2],2'b00})
- mem_cmd_wdata  out  32  lane-replicated store data
- mem_cmd_wmask  out  4  byte-enable mask
- mem_rsp_valid  in  1  read data valid
- mem_rsp_rdata  in  32  read word
- wb_valid  out  1  load result valid
- wb_ready  in  1  writeback accepts the result
- wb_rd  out  5  destination register
- wb_data  out  32  aligned and extended load data
- agu_misalign  out  1  one-cycle address-error pulse

## Operation
- FSM states: IDLE, ADDR, CMD, RSP, WB, ERR.
- IDLE: agu_i_ready=1. On agu_i_valid, register all agu_i_* fields and go to ADDR.
- ADDR: drive agu_req_alu=1, agu_req_alu_add=1, op1=rs, op2=imm. Capture ea=agu_req_alu_res at the clock edge.
  - Go to ERR if any of: size=11; size=01 with ea[0]=1; size=10 with ea[1:0]≠0.
  - Otherwise go to CMD.
- ERR: agu_misalign=1 for one cycle. No memory command is issued. Go to IDLE.
- CMD: mem_cmd_valid=1. All mem_cmd_* outputs stay stable until mem_cmd_ready.
  - On a handshake, a load goes to RSP and a store goes to IDLE.
- Store lane rules (little-endian):
  - byte: wdata={4{d[7:0]}}, wmask=4'b0001<<ea[1:0]
  - half: wdata={2{d[15:0]}}, wmask=4'b0011<<ea[1:0]
  - word: wdata=d, wmask=4'b1111
  - For loads, wmask=0 and wdata=0.
- RSP: wait for mem_rsp_valid. Then shift: s = rdata>>(8*ea[1:0]).
  - byte: wb_data = usign ? {24'b0,s[7:0]} : {{24{s[7]}},s[7:0]}
  - half: same pattern on s[15:0]
  - word: wb_data = rdata
  - Register wb_data and wb_rd, then go to WB.
- WB: wb_valid=1 with wb_data and wb_rd held until wb_ready. Then go to IDLE.
- mem_rsp_valid is ignored in every state other than RSP.
- Address arithmetic wraps modulo 2^32. No overflow trap.

## Timing
- Reset (async, any state) forces IDLE. Reset values:
  - agu_i_ready=1
  - all other outputs 0
  - internal registers 0
- A response that arrives after a mid-operation reset is dropped.
- All outputs are registered or decoded from state only. The only combinational input→output path is agu_req_alu_res→ea register.
- Minimum latencies, with handshake in cycle 0:
  - store: ADDR=1, CMD=2. Command accepted in cycle 2; agu_i_ready=1 again in cycle 3.
  - load: response earliest in cycle 3 (responder latency ≥1 cycle after the command); wb_valid in cycle 4.
  - misaligned: agu_misalign in cycle 2; agu_i_ready in cycle 3.
- Back-pressure on mem_cmd_ready or wb_ready stalls with no loss or change of data.
- agu_req_alu is high for exactly one cycle per instruction.

## Test plan
- SW rs=0x1000, imm=4, d=0xDEADBEEF, ready tied 1 -> cycle 2: addr=0x1004, wmask=1111, wdata=0xDEADBEEF, read=0. No wb_valid.
- SB ea=0x1003, d=0x000000A5 -> wdata=0xA5A5A5A5, wmask=1000. SH ea=0x1002, d=0x1234 -> wdata=0x12341234, wmask=1100.
- LB ea=0x2001, rdata=0x0080FF00 -> wb_data=0xFFFFFFFF. LBU same -> 0x000000FF. LH ea=0x2002, rdata=0x80000000 -> 0xFFFF8000.
- LW rs=0x3000, imm=-2 -> ea=0x2FFE, agu_misalign pulses in cycle 2, mem_cmd_valid never asserted. size=11 -> same pulse.
- Load with mem_cmd_ready low 3 cycles and wb_ready low 2 cycles -> mem_cmd_* and wb_* held stable, single handshake each, correct wb_rd.
- Assert rst while in RSP, then pulse mem_rsp_valid -> all outputs 0, agu_i_ready=1, no wb_valid.

Source files
------------

// File: rtl/mips_ex_agu_ctrl.sv
`default_nettype none
// ============================================================================
// mips_ex_agu_ctrl : EX-stage load/store sequencer (AGU add, memory command,
//                    load response alignment/extension, misalign detection)
// Revision 1.0
// ============================================================================
module mips_ex_agu_ctrl #(
    parameter int MIPS_DATA_WIDTH = 32,
    parameter int MIPS_ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       agu_i_valid,
    output logic                       agu_i_ready,
    input  logic                       agu_i_load,
    input  logic [1:0]                 agu_i_size,
    input  logic                       agu_i_usign,
    input  logic [MIPS_DATA_WIDTH-1:0] agu_i_rs,
    input  logic [MIPS_DATA_WIDTH-1:0] agu_i_imm,
    input  logic [MIPS_DATA_WIDTH-1:0] agu_i_wdata,
    input  logic [4:0]                 agu_i_rd,
    output logic                       agu_req_alu,
    output logic [MIPS_DATA_WIDTH-1:0] agu_req_alu_op1,
    output logic [MIPS_DATA_WIDTH-1:0] agu_req_alu_op2,
    output logic                       agu_req_alu_add,
    input  logic [MIPS_DATA_WIDTH-1:0] agu_req_alu_res,
    output logic                       mem_cmd_valid,
    input  logic                       mem_cmd_ready,
    output logic                       mem_cmd_read,
    output logic [MIPS_ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [MIPS_DATA_WIDTH-1:0] mem_cmd_wdata,
    output logic [3:0]                 mem_cmd_wmask,
    input  logic                       mem_rsp_valid,
    input  logic [MIPS_DATA_WIDTH-1:0] mem_rsp_rdata,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [4:0]                 wb_rd,
    output logic [MIPS_DATA_WIDTH-1:0] wb_data,
    output logic                       agu_misalign
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_CMD  = 3'd2,
        S_RSP  = 3'd3,
        S_WB   = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                     state_q, state_d;
    logic                       load_q, load_d;
    logic [1:0]                 size_q, size_d;
    logic                       usign_q, usign_d;
    logic [MIPS_DATA_WIDTH-1:0] rs_q, rs_d;
    logic [MIPS_DATA_WIDTH-1:0] imm_q, imm_d;
    logic [MIPS_DATA_WIDTH-1:0] sdata_q, sdata_d;
    logic [4:0]                 rd_q, rd_d;
    logic [MIPS_DATA_WIDTH-1:0] ea_q, ea_d;
    logic [MIPS_DATA_WIDTH-1:0] wbdata_q, wbdata_d;

    logic                       w_misalign;
    logic [MIPS_DATA_WIDTH-1:0] w_shift;
    logic [MIPS_DATA_WIDTH-1:0] w_ld_data;
    logic [MIPS_DATA_WIDTH-1:0] w_st_data;
    logic [3:0]                 w_st_mask;

    // Alignment is judged on the live ALU sum so ERR is entered straight from ADDR.
    always_comb begin
        w_misalign = 1'b0;
        case (size_q)
            SZ_BYTE: w_misalign = 1'b0;
            SZ_HALF: w_misalign = agu_req_alu_res[0];
            SZ_WORD: w_misalign = |agu_req_alu_res[1:0];
            default: w_misalign = 1'b1;
        endcase
    end

    assign w_shift = mem_rsp_rdata >> {ea_q[1:0], 3'b000};

    always_comb begin
        w_ld_data = mem_rsp_rdata;
        case (size_q)
            SZ_BYTE: w_ld_data = usign_q ? {24'b0, w_shift[7:0]}
                                         : {{24{w_shift[7]}}, w_shift[7:0]};
            SZ_HALF: w_ld_data = usign_q ? {16'b0, w_shift[15:0]}
                                         : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_ld_data = mem_rsp_rdata;
        endcase
    end

    always_comb begin
        w_st_data = sdata_q;
        w_st_mask = 4'b1111;
        case (size_q)
            SZ_BYTE: begin
                w_st_data = {4{sdata_q[7:0]}};
                w_st_mask = 4'b0001 << ea_q[1:0];
            end
            SZ_HALF: begin
                w_st_data = {2{sdata_q[15:0]}};
                w_st_mask = 4'b0011 << ea_q[1:0];
            end
            default: begin
                w_st_data = sdata_q;
                w_st_mask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        size_d   = size_q;
        usign_d  = usign_q;
        rs_d     = rs_q;
        imm_d    = imm_q;
        sdata_d  = sdata_q;
        rd_d     = rd_q;
        ea_d     = ea_q;
        wbdata_d = wbdata_q;
        case (state_q)
            S_IDLE: begin
                if (agu_i_valid) begin
                    load_d  = agu_i_load;
                    size_d  = agu_i_size;
                    usign_d = agu_i_usign;
                    rs_d    = agu_i_rs;
                    imm_d   = agu_i_imm;
                    sdata_d = agu_i_wdata;
                    rd_d    = agu_i_rd;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                ea_d    = agu_req_alu_res;
                state_d = w_misalign ? S_ERR : S_CMD;
            end
            S_ERR: state_d = S_IDLE;
            S_CMD: begin
                if (mem_cmd_ready) begin
                    state_d = load_q ? S_RSP : S_IDLE;
                end
            end
            S_RSP: begin
                if (mem_rsp_valid) begin
                    wbdata_d = w_ld_data;
                    state_d  = S_WB;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            load_q   <= 1'b0;
            size_q   <= 2'b00;
            usign_q  <= 1'b0;
            rs_q     <= '0;
            imm_q    <= '0;
            sdata_q  <= '0;
            rd_q     <= 5'd0;
            ea_q     <= '0;
            wbdata_q <= '0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            size_q   <= size_d;
            usign_q  <= usign_d;
            rs_q     <= rs_d;
            imm_q    <= imm_d;
            sdata_q  <= sdata_d;
            rd_q     <= rd_d;
            ea_q     <= ea_d;
            wbdata_q <= wbdata_d;
        end
    end

    // Every output is a state decode gating registered data, so idle outputs read as zero.
    assign agu_i_ready     = (state_q == S_IDLE);
    assign agu_req_alu     = (state_q == S_ADDR);
    assign agu_req_alu_add = (state_q == S_ADDR);
    assign agu_req_alu_op1 = (state_q == S_ADDR) ? rs_q  : '0;
    assign agu_req_alu_op2 = (state_q == S_ADDR) ? imm_q : '0;

    assign mem_cmd_valid = (state_q == S_CMD);
    assign mem_cmd_read  = (state_q == S_CMD) && load_q;
    assign mem_cmd_addr  = (state_q == S_CMD) ? {ea_q[MIPS_ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_cmd_wdata = ((state_q == S_CMD) && !load_q) ? w_st_data : '0;
    assign mem_cmd_wmask = ((state_q == S_CMD) && !load_q) ? w_st_mask : 4'b0000;

    assign wb_valid     = (state_q == S_WB);
    assign wb_rd        = (state_q == S_WB) ? rd_q     : 5'd0;
    assign wb_data      = (state_q == S_WB) ? wbdata_q : '0;
    assign agu_misalign = (state_q == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_mips_ex_agu_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mips_ex_agu_ctrl : directed bench for the EX-stage load/store sequencer
// Revision 1.0
// ============================================================================
module tb_mips_ex_agu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        agu_i_valid = 1'b0;
    logic        agu_i_ready;
    logic        agu_i_load = 1'b0;
    logic [1:0]  agu_i_size = 2'b00;
    logic        agu_i_usign = 1'b0;
    logic [31:0] agu_i_rs = '0;
    logic [31:0] agu_i_imm = '0;
    logic [31:0] agu_i_wdata = '0;
    logic [4:0]  agu_i_rd = '0;
    logic        agu_req_alu;
    logic [31:0] agu_req_alu_op1;
    logic [31:0] agu_req_alu_op2;
    logic        agu_req_alu_add;
    logic [31:0] agu_req_alu_res;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready = 1'b1;
    logic        mem_cmd_read;
    logic [31:0] mem_cmd_addr;
    logic [31:0] mem_cmd_wdata;
    logic [3:0]  mem_cmd_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        agu_misalign;

    int vectors = 0;
    int errors  = 0;
    int cmd_hs  = 0;
    int wb_hs   = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared ALU: combinational adder.
    assign agu_req_alu_res = agu_req_alu_op1 + agu_req_alu_op2;

    always @(posedge clk) begin
        if (mem_cmd_valid && mem_cmd_ready) cmd_hs++;
        if (wb_valid && wb_ready) wb_hs++;
    end

    mips_ex_agu_ctrl #(.MIPS_DATA_WIDTH(32), .MIPS_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .agu_i_valid(agu_i_valid), .agu_i_ready(agu_i_ready),
        .agu_i_load(agu_i_load), .agu_i_size(agu_i_size), .agu_i_usign(agu_i_usign),
        .agu_i_rs(agu_i_rs), .agu_i_imm(agu_i_imm), .agu_i_wdata(agu_i_wdata),
        .agu_i_rd(agu_i_rd),
        .agu_req_alu(agu_req_alu), .agu_req_alu_op1(agu_req_alu_op1),
        .agu_req_alu_op2(agu_req_alu_op2), .agu_req_alu_add(agu_req_alu_add),
        .agu_req_alu_res(agu_req_alu_res),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_read(mem_cmd_read), .mem_cmd_addr(mem_cmd_addr),
        .mem_cmd_wdata(mem_cmd_wdata), .mem_cmd_wmask(mem_cmd_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .agu_misalign(agu_misalign)
    );

    // Called at a negedge with the DUT idle; returns at the negedge of cycle 1.
    task automatic offer(input logic ld, input logic [1:0] sz, input logic us,
                         input logic [31:0] rs, input logic [31:0] imm,
                         input logic [31:0] wd, input logic [4:0] rd);
        agu_i_valid = 1'b1; agu_i_load = ld; agu_i_size = sz; agu_i_usign = us;
        agu_i_rs = rs; agu_i_imm = imm; agu_i_wdata = wd; agu_i_rd = rd;
        @(negedge clk);
        agu_i_valid = 1'b0; agu_i_rs = '0; agu_i_imm = '0; agu_i_wdata = '0; agu_i_rd = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (agu_i_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", agu_i_ready); end
        vectors++; if ({agu_req_alu, agu_req_alu_add, mem_cmd_valid, mem_cmd_read, wb_valid, agu_misalign} !== 6'b0)
            begin errors++; $display("FAIL rst_ctrl: got %b exp 000000", {agu_req_alu, agu_req_alu_add, mem_cmd_valid, mem_cmd_read, wb_valid, agu_misalign}); end
        vectors++; if ({mem_cmd_addr, mem_cmd_wdata, mem_cmd_wmask, wb_data, wb_rd, agu_req_alu_op1, agu_req_alu_op2} !== '0)
            begin errors++; $display("FAIL rst_data: got addr %h wdata %h wb %h exp 0", mem_cmd_addr, mem_cmd_wdata, wb_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store(input logic [1:0] sz, input logic [31:0] rs, input logic [31:0] imm,
                              input logic [31:0] d, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_wmask);
        offer(1'b0, sz, 1'b0, rs, imm, d, 5'd0);
        vectors++; if ({agu_req_alu, agu_req_alu_add} !== 2'b11) begin errors++; $display("FAIL st_aluReq: got %b exp 11", {agu_req_alu, agu_req_alu_add}); end
        vectors++; if (agu_req_alu_op1 !== rs || agu_req_alu_op2 !== imm)
            begin errors++; $display("FAIL st_ops: got %h/%h exp %h/%h", agu_req_alu_op1, agu_req_alu_op2, rs, imm); end
        @(negedge clk);
        vectors++; if (mem_cmd_valid !== 1'b1 || mem_cmd_read !== 1'b0) begin errors++; $display("FAIL st_cmd: got v%b r%b exp v1 r0", mem_cmd_valid, mem_cmd_read); end
        vectors++; if (mem_cmd_addr !== exp_addr) begin errors++; $display("FAIL st_addr: got %h exp %h", mem_cmd_addr, exp_addr); end
        vectors++; if (mem_cmd_wdata !== exp_wdata) begin errors++; $display("FAIL st_wdata: got %h exp %h", mem_cmd_wdata, exp_wdata); end
        vectors++; if (mem_cmd_wmask !== exp_wmask) begin errors++; $display("FAIL st_wmask: got %b exp %b", mem_cmd_wmask, exp_wmask); end
        vectors++; if (agu_req_alu !== 1'b0) begin errors++; $display("FAIL st_aluOnce: got %b exp 0", agu_req_alu); end
        @(negedge clk);
        vectors++; if (agu_i_ready !== 1'b1 || mem_cmd_valid !== 1'b0 || wb_valid !== 1'b0)
            begin errors++; $display("FAIL st_done: got rdy%b v%b wb%b exp 1 0 0", agu_i_ready, mem_cmd_valid, wb_valid); end
    endtask

    task automatic test_load(input logic [1:0] sz, input logic us, input logic [31:0] rs,
                             input logic [31:0] imm, input logic [4:0] rd, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data);
        offer(1'b1, sz, us, rs, imm, 32'hFFFF_FFFF, rd);
        @(negedge clk);
        vectors++; if (mem_cmd_valid !== 1'b1 || mem_cmd_read !== 1'b1) begin errors++; $display("FAIL ld_cmd: got v%b r%b exp v1 r1", mem_cmd_valid, mem_cmd_read); end
        vectors++; if (mem_cmd_addr !== exp_addr) begin errors++; $display("FAIL ld_addr: got %h exp %h", mem_cmd_addr, exp_addr); end
        vectors++; if (mem_cmd_wmask !== 4'b0000 || mem_cmd_wdata !== 32'h0)
            begin errors++; $display("FAIL ld_wzero: got %b/%h exp 0000/0", mem_cmd_wmask, mem_cmd_wdata); end
        @(negedge clk);
        vectors++; if (mem_cmd_valid !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL ld_rsp: got v%b wb%b exp 0 0", mem_cmd_valid, wb_valid); end
        mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        vectors++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL ld_wbv: got %b exp 1", wb_valid); end
        vectors++; if (wb_data !== exp_data) begin errors++; $display("FAIL ld_data: got %h exp %h", wb_data, exp_data); end
        vectors++; if (wb_rd !== rd) begin errors++; $display("FAIL ld_rd: got %0d exp %0d", wb_rd, rd); end
        @(negedge clk);
        vectors++; if (wb_valid !== 1'b0 || agu_i_ready !== 1'b1) begin errors++; $display("FAIL ld_done: got wb%b rdy%b exp 0 1", wb_valid, agu_i_ready); end
    endtask

    task automatic test_misalign(input logic [1:0] sz, input logic [31:0] rs, input logic [31:0] imm);
        int hs0;
        hs0 = cmd_hs;
        offer(1'b1, sz, 1'b0, rs, imm, 32'h0, 5'd1);
        vectors++; if (agu_misalign !== 1'b0) begin errors++; $display("FAIL ma_early: got %b exp 0", agu_misalign); end
        @(negedge clk);
        vectors++; if (agu_misalign !== 1'b1 || mem_cmd_valid !== 1'b0)
            begin errors++; $display("FAIL ma_pulse: got err%b v%b exp 1 0", agu_misalign, mem_cmd_valid); end
        @(negedge clk);
        vectors++; if (agu_misalign !== 1'b0 || agu_i_ready !== 1'b1 || mem_cmd_valid !== 1'b0)
            begin errors++; $display("FAIL ma_end: got err%b rdy%b v%b exp 0 1 0", agu_misalign, agu_i_ready, mem_cmd_valid); end
        vectors++; if (cmd_hs !== hs0) begin errors++; $display("FAIL ma_nocmd: got %0d exp %0d", cmd_hs, hs0); end
    endtask

    task automatic test_backpressure();
        int c0, w0;
        c0 = cmd_hs; w0 = wb_hs;
        mem_cmd_ready = 1'b0; wb_ready = 1'b0;
        offer(1'b1, 2'b10, 1'b0, 32'h4000, 32'h8, 32'h0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (mem_cmd_valid !== 1'b1 || mem_cmd_read !== 1'b1 || mem_cmd_addr !== 32'h4008)
                begin errors++; $display("FAIL bp_cmdHold%0d: got v%b r%b %h exp 1 1 00004008", i, mem_cmd_valid, mem_cmd_read, mem_cmd_addr); end
        end
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        mem_cmd_ready = 1'b0;
        vectors++; if (mem_cmd_valid !== 1'b0 || cmd_hs !== c0 + 1) begin errors++; $display("FAIL bp_cmdHs: got v%b n%0d exp 0 %0d", mem_cmd_valid, cmd_hs, c0 + 1); end
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            vectors++; if (wb_valid !== 1'b1 || wb_data !== 32'hCAFE_F00D || wb_rd !== 5'd9)
                begin errors++; $display("FAIL bp_wbHold%0d: got v%b %h rd%0d exp 1 cafef00d rd9", i, wb_valid, wb_data, wb_rd); end
            if (i == 0) @(negedge clk);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        mem_cmd_ready = 1'b1;
        vectors++; if (wb_valid !== 1'b0 || wb_hs !== w0 + 1) begin errors++; $display("FAIL bp_wbHs: got v%b n%0d exp 0 %0d", wb_valid, wb_hs, w0 + 1); end
    endtask

    task automatic test_reset_mid();
        offer(1'b1, 2'b10, 1'b0, 32'h5000, 32'h0, 32'h0, 5'd3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++; if (agu_i_ready !== 1'b1 || mem_cmd_valid !== 1'b0 || wb_valid !== 1'b0 || agu_misalign !== 1'b0 || agu_req_alu !== 1'b0)
            begin errors++; $display("FAIL rm_ctrl: got rdy%b v%b wb%b err%b alu%b exp 1 0 0 0 0", agu_i_ready, mem_cmd_valid, wb_valid, agu_misalign, agu_req_alu); end
        vectors++; if (wb_data !== 32'h0 || wb_rd !== 5'd0 || mem_cmd_addr !== 32'h0)
            begin errors++; $display("FAIL rm_data: got %h rd%0d %h exp 0", wb_data, wb_rd, mem_cmd_addr); end
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1111_1111;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            vectors++; if (wb_valid !== 1'b0 || agu_i_ready !== 1'b1)
                begin errors++; $display("FAIL rm_drop%0d: got wb%b rdy%b exp 0 1", i, wb_valid, agu_i_ready); end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_store(2'b10, 32'h1000, 32'h4, 32'hDEAD_BEEF, 32'h1004, 32'hDEAD_BEEF, 4'b1111);
        test_store(2'b00, 32'h1000, 32'h3, 32'h0000_00A5, 32'h1000, 32'hA5A5_A5A5, 4'b1000);
        test_store(2'b01, 32'h1000, 32'h2, 32'h0000_1234, 32'h1000, 32'h1234_1234, 4'b1100);
        test_load(2'b00, 1'b0, 32'h2000, 32'h1, 5'd5,  32'h0080_FF00, 32'h2000, 32'hFFFF_FFFF);
        test_load(2'b00, 1'b1, 32'h2000, 32'h1, 5'd6,  32'h0080_FF00, 32'h2000, 32'h0000_00FF);
        test_load(2'b01, 1'b0, 32'h2000, 32'h2, 5'd7,  32'h8000_0000, 32'h2000, 32'hFFFF_8000);
        test_load(2'b01, 1'b1, 32'h2000, 32'h2, 5'd8,  32'h8000_0000, 32'h2000, 32'h0000_8000);
        test_load(2'b10, 1'b0, 32'hFFFF_FFFC, 32'h8, 5'd31, 32'h89AB_CDEF, 32'h0000_0004, 32'h89AB_CDEF);
        test_misalign(2'b10, 32'h3000, 32'hFFFF_FFFE);
        test_misalign(2'b11, 32'h3000, 32'h0);
        test_misalign(2'b01, 32'h3000, 32'h1);
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
